// File: rtl/spl_if_pkg.sv
// Shared widths and request types for the SPL cache-line memory responder.
package spl_if_pkg;

  localparam int CL_W   = 512;
  localparam int ADDR_W = 58;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CL_W-1:0]   data;
  } wr_req_t;

endpackage

// File: rtl/spl_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers; pushes into a full FIFO are dropped.
module spl_sync_fifo #(
  parameter int W  = 58,
  parameter int AW = 4
) (
  input  logic          CLK_400M,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0] mem [0:(2**AW)-1];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign count    = wr_ptr - rd_ptr;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK_400M) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge CLK_400M) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spl_mem_responder.sv
// Memory-side SPL responder: queues read/write requests, services them from a single-port line RAM,
// returns in-order read responses after a fixed latency and raises almostfull as backpressure.
module spl_mem_responder
  import spl_if_pkg::*;
#(
  parameter int MEM_AW    = 10,
  parameter int RD_LAT    = 4,
  parameter int Q_AW      = 4,
  parameter int AF_THRESH = 10
) (
  input  logic              CLK_400M,
  input  logic              reset_n,
  input  logic              cor_tx_rd_valid,
  input  logic [ADDR_W-1:0] cor_tx_rd_addr,
  input  logic              cor_tx_wr_valid,
  input  logic              cor_tx_fence_valid,
  input  logic [ADDR_W-1:0] cor_tx_wr_addr,
  input  logic [CL_W-1:0]   cor_tx_data,
  output logic              spl_tx_rd_almostfull,
  output logic              spl_tx_wr_almostfull,
  output logic              io_rx_rd_valid,
  output logic [CL_W-1:0]   io_rx_data,
  output logic              rd_overflow,
  output logic              wr_overflow
);

  localparam logic [Q_AW:0] AF_LVL = (Q_AW+1)'(AF_THRESH);

  logic [ADDR_W-1:0] rdq_addr;
  logic              rdq_full, rdq_empty;
  logic [Q_AW:0]     rdq_count, rdq_count_nxt;
  wr_req_t           wrq_in, wrq_out;
  logic              wrq_full, wrq_empty;
  logic [Q_AW:0]     wrq_count, wrq_count_nxt;

  logic              rd_push, wr_push, fence_in;
  logic              wrq_urgent, do_rd, do_wr;
  logic              fence_pending, fence_nxt;

  logic [CL_W-1:0]   ram [0:(2**MEM_AW)-1];
  logic [CL_W-1:0]   ram_q;
  logic              ram_vld;
  logic [RD_LAT-1:0] pipe_vld;
  logic [CL_W-1:0]   pipe_data [RD_LAT];

  logic              unused_addr_hi;

  assign rd_push  = cor_tx_rd_valid;
  assign wr_push  = cor_tx_wr_valid && !cor_tx_fence_valid;
  assign fence_in = cor_tx_wr_valid && cor_tx_fence_valid;
  assign wrq_in   = '{addr: cor_tx_wr_addr, data: cor_tx_data};

  spl_sync_fifo #(.W(ADDR_W), .AW(Q_AW)) u_rdq (
    .CLK_400M  (CLK_400M),
    .reset_n   (reset_n),
    .push      (rd_push),
    .push_data (cor_tx_rd_addr),
    .pop       (do_rd),
    .pop_data  (rdq_addr),
    .full      (rdq_full),
    .empty     (rdq_empty),
    .count     (rdq_count)
  );

  spl_sync_fifo #(.W($bits(wr_req_t)), .AW(Q_AW)) u_wrq (
    .CLK_400M  (CLK_400M),
    .reset_n   (reset_n),
    .push      (wr_push),
    .push_data (wrq_in),
    .pop       (do_wr),
    .pop_data  (wrq_out),
    .full      (wrq_full),
    .empty     (wrq_empty),
    .count     (wrq_count)
  );

  // One RAM access per cycle: urgent writes, then reads (blocked by a fence), then background writes.
  assign wrq_urgent = !wrq_empty && (fence_pending || (wrq_count >= AF_LVL));
  assign do_rd      = !rdq_empty && !fence_pending && !wrq_urgent;
  assign do_wr      = !wrq_empty && !do_rd;

  assign rdq_count_nxt = rdq_count + (Q_AW+1)'(rd_push && !rdq_full) - (Q_AW+1)'(do_rd);
  assign wrq_count_nxt = wrq_count + (Q_AW+1)'(wr_push && !wrq_full) - (Q_AW+1)'(do_wr);
  assign fence_nxt     = fence_in || (fence_pending && (wrq_count_nxt != '0));

  always_ff @(posedge CLK_400M) begin
    if (reset_n && do_wr) begin
      ram[wrq_out.addr[MEM_AW-1:0]] <= wrq_out.data;
    end else if (reset_n && do_rd) begin
      ram_q <= ram[rdq_addr[MEM_AW-1:0]];
    end
  end

  always_ff @(posedge CLK_400M) begin
    if (!reset_n) begin
      fence_pending        <= 1'b0;
      spl_tx_rd_almostfull <= 1'b0;
      spl_tx_wr_almostfull <= 1'b0;
      rd_overflow          <= 1'b0;
      wr_overflow          <= 1'b0;
      ram_vld              <= 1'b0;
      pipe_vld             <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_data[i] <= '0;
    end else begin
      fence_pending        <= fence_nxt;
      spl_tx_rd_almostfull <= (rdq_count_nxt >= AF_LVL);
      spl_tx_wr_almostfull <= (wrq_count_nxt >= AF_LVL) || fence_nxt;
      if (rd_push && rdq_full) rd_overflow <= 1'b1;
      if (wr_push && wrq_full) wr_overflow <= 1'b1;
      ram_vld      <= do_rd;
      pipe_vld[0]  <= ram_vld;
      pipe_data[0] <= ram_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign io_rx_rd_valid = pipe_vld[RD_LAT-1];
  assign io_rx_data     = pipe_data[RD_LAT-1];

  // Lines beyond the RAM depth alias; the upper address bits are intentionally ignored.
  assign unused_addr_hi = ^{rdq_addr[ADDR_W-1:MEM_AW], wrq_out.addr[ADDR_W-1:MEM_AW]};

endmodule

// File: tb/tb_spl_mem_responder.sv
// Randomized bench for spl_mem_responder against a line-map model with an in-order expected queue.
`timescale 1ns/1ps
module tb_spl_mem_responder;
  import spl_if_pkg::*;

  localparam int RD_LAT    = 4;
  localparam int AF_THRESH = 10;

  logic              CLK_400M = 1'b0;
  logic              reset_n  = 1'b0;
  logic              cor_tx_rd_valid = 1'b0;
  logic [ADDR_W-1:0] cor_tx_rd_addr  = '0;
  logic              cor_tx_wr_valid = 1'b0;
  logic              cor_tx_fence_valid = 1'b0;
  logic [ADDR_W-1:0] cor_tx_wr_addr  = '0;
  logic [CL_W-1:0]   cor_tx_data     = '0;
  logic              spl_tx_rd_almostfull, spl_tx_wr_almostfull;
  logic              io_rx_rd_valid;
  logic [CL_W-1:0]   io_rx_data;
  logic              rd_overflow, wr_overflow;

  spl_mem_responder #(.MEM_AW(10), .RD_LAT(RD_LAT), .Q_AW(4), .AF_THRESH(AF_THRESH)) dut (
    .CLK_400M             (CLK_400M),
    .reset_n              (reset_n),
    .cor_tx_rd_valid      (cor_tx_rd_valid),
    .cor_tx_rd_addr       (cor_tx_rd_addr),
    .cor_tx_wr_valid      (cor_tx_wr_valid),
    .cor_tx_fence_valid   (cor_tx_fence_valid),
    .cor_tx_wr_addr       (cor_tx_wr_addr),
    .cor_tx_data          (cor_tx_data),
    .spl_tx_rd_almostfull (spl_tx_rd_almostfull),
    .spl_tx_wr_almostfull (spl_tx_wr_almostfull),
    .io_rx_rd_valid       (io_rx_rd_valid),
    .io_rx_data           (io_rx_data),
    .rd_overflow          (rd_overflow),
    .wr_overflow          (wr_overflow)
  );

  // ---------------- clock / reset ----------------
  always #1.25 CLK_400M = ~CLK_400M;

  int cyc = 0;
  always @(posedge CLK_400M) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [CL_W-1:0] ref_mem [int];
  logic [CL_W-1:0] exp_q[$];
  int rsp_cnt = 0;
  int last_rsp_cyc = 0;
  int rsp_cyc_q[$];

  task automatic check(input string tag, input logic [CL_W-1:0] got, input logic [CL_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK_400M) begin
    if (reset_n && io_rx_rd_valid) begin
      rsp_cnt++;
      last_rsp_cyc = cyc;
      rsp_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else                   check("rsp_data", io_rx_data, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [CL_W-1:0] rand_cl();
    logic [CL_W-1:0] d;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [CL_W-1:0] pat(input int v);
    logic [CL_W-1:0] d;
    for (int k = 0; k < 16; k++) d[32*k +: 32] = 32'(v);
    return d;
  endfunction

  task automatic step();
    @(posedge CLK_400M);
    #0.5;
    cor_tx_rd_valid    = 1'b0;
    cor_tx_wr_valid    = 1'b0;
    cor_tx_fence_valid = 1'b0;
  endtask

  task automatic req_read(input int line, input bit accepted);
    cor_tx_rd_valid = 1'b1;
    cor_tx_rd_addr  = ADDR_W'(line);
    if (accepted) exp_q.push_back(ref_mem[line]);
  endtask

  task automatic req_write(input int line, input logic [CL_W-1:0] d);
    cor_tx_wr_valid    = 1'b1;
    cor_tx_fence_valid = 1'b0;
    cor_tx_wr_addr     = ADDR_W'(line);
    cor_tx_data        = d;
    ref_mem[line]      = d;
  endtask

  task automatic req_fence();
    cor_tx_wr_valid    = 1'b1;
    cor_tx_fence_valid = 1'b1;
    cor_tx_wr_addr     = $urandom;
    cor_tx_data        = rand_cl();
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
    repeat (6) step();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, io_rx_rd_valid, 0);
    check({tag, "_data"}, io_rx_data, 0);
    check({tag, "_rd_af"}, spl_tx_rd_almostfull, 0);
    check({tag, "_wr_af"}, spl_tx_wr_almostfull, 0);
    check({tag, "_rd_ovf"}, rd_overflow, 0);
    check({tag, "_wr_ovf"}, wr_overflow, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t_req, base, n, span;

    reset_n = 1'b0;
    repeat (3) step();
    check_outputs_zero("rst");
    reset_n = 1'b1;
    step();

    // Single write then read: fixed latency from request cycle.
    req_write(5, {16{32'hA5A5_0005}});
    step();
    repeat (6) step();
    base  = rsp_cnt;
    t_req = cyc;
    req_read(5, 1'b1);
    step();
    wait_drain("t1_drain");
    check("t1_latency", last_rsp_cyc - t_req, 2 + RD_LAT);
    check("t1_count", rsp_cnt - base, 1);

    // Preload line i = i, then 16 back-to-back reads.
    for (int i = 0; i < 16; i++) begin
      req_write(i, pat(i));
      step();
    end
    repeat (10) step();
    rsp_cyc_q.delete();
    for (int i = 0; i < 16; i++) begin
      req_read(i, 1'b1);
      step();
    end
    wait_drain("t2_drain");
    check("t2_count", rsp_cyc_q.size(), 16);
    span = (rsp_cyc_q.size() > 0) ? rsp_cyc_q[rsp_cyc_q.size()-1] - rsp_cyc_q[0] : -1;
    check("t2_consecutive", span, 15);

    // Writes backed up behind reads, then a fence orders the following reads behind them.
    for (int i = 0; i < 8; i++) begin
      req_read(i, 1'b1);
      req_write(32'h20 + i, rand_cl());
      step();
    end
    req_fence();
    step();
    for (int i = 0; i < 8; i++) begin
      req_read(32'h20 + i, 1'b1);
      step();
    end
    wait_drain("t3_drain");
    check("t3_rd_ovf", rd_overflow, 0);
    check("t3_wr_ovf", wr_overflow, 0);

    // Fence held by continuous writes while reads pile up past full.
    req_write(32'h60, rand_cl());
    step();
    req_write(32'h61, rand_cl());
    step();
    req_fence();
    step();
    base = rsp_cnt;
    for (int k = 1; k <= 20; k++) begin
      req_read(k - 1, k <= 16);
      req_write(32'h62 + k, rand_cl());
      step();
      check($sformatf("t4_rd_af_%0d", k), spl_tx_rd_almostfull, k >= AF_THRESH);
      check($sformatf("t4_rd_ovf_%0d", k), rd_overflow, k >= 17);
      check($sformatf("t4_wr_af_%0d", k), spl_tx_wr_almostfull, 1);
    end
    check("t4_no_early_rsp", rsp_cnt - base, 0);
    for (int k = 0; k < 3; k++) begin
      req_write(32'h80 + k, rand_cl());
      step();
    end
    wait_drain("t4_drain");
    check("t4_rsp_count", rsp_cnt - base, 16);
    check("t4_ovf_sticky", rd_overflow, 1);
    check("t4_wr_ovf", wr_overflow, 0);

    // Random mixed traffic on disjoint line pools, honouring almostfull.
    for (int c = 0; c < 50; c++) begin
      if ($urandom_range(0, 1) == 1 && !spl_tx_rd_almostfull) req_read($urandom_range(0, 15), 1'b1);
      if ($urandom_range(0, 1) == 1 && !spl_tx_wr_almostfull)
        req_write(32'h40 + $urandom_range(0, 15), rand_cl());
      step();
    end
    req_fence();
    step();
    for (int line = 32'h40; line < 32'h50; line++) begin
      if (ref_mem.exists(line)) begin
        n = 0;
        while (spl_tx_rd_almostfull && n < 100) begin
          step();
          n++;
        end
        check("t5_af_timeout", n >= 100, 0);
        req_read(line, 1'b1);
        step();
      end
    end
    wait_drain("t5_drain");
    check("t5_wr_ovf", wr_overflow, 0);

    // Reset with reads in flight.
    for (int i = 0; i < 3; i++) begin
      req_read(i, 1'b1);
      step();
    end
    step();
    reset_n = 1'b0;
    step();
    check_outputs_zero("t6_rst");
    exp_q.delete();
    reset_n = 1'b1;
    base = rsp_cnt;
    repeat (25) step();
    check("t6_no_rsp", rsp_cnt - base, 0);
    req_read(5, 1'b1);
    step();
    wait_drain("t6_ram_kept");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
